uart_tx_feeder: RTL and testbench

//  Single-clock pump between the TX-domain read side of the async FIFO and the UART transmitter.

---
 rtl/uart_tx_feeder_if.sv | 32 +++
 rtl/uart_tx_feeder.sv | 147 ++++++++++++++
 tb/tb_uart_tx_feeder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - FIFO read side and UART transmitter parallel port bundle.
interface uart_tx_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_inc;
  logic [DATA_WIDTH-1:0] tx_p_data;
  logic                  tx_data_valid;
  logic                  tx_busy;
  logic                  tx_started;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  tx_busy,
    input  tx_started,
    output fifo_rd_inc,
    output tx_p_data,
    output tx_data_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output tx_busy,
    output tx_started,
    input  fifo_rd_inc,
    input  tx_p_data,
    input  tx_data_valid
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - pops FIFO bytes into the UART transmitter with start watchdog and frame count.
// Optional inter-frame gap state and Gap_Cycles input enabled by UART_TX_GAP_EN.
module uart_tx_feeder #(
  parameter int DATA_WIDTH    = 8,
`ifdef UART_TX_GAP_EN
  parameter int GAP_W         = 8,
`endif
  parameter int START_TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  uart_tx_feeder_if.master   bus,
`ifdef UART_TX_GAP_EN
  input  logic [GAP_W-1:0]   gap_cycles_i,
`endif
  output logic [15:0]        frame_count_o,
  output logic               timeout_err_o,
  output logic               idle_o
);

  localparam int WD_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_RETRY,
`ifdef UART_TX_GAP_EN
    S_GAP,
`endif
    S_WAIT_DONE
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  rd_inc_q;
  logic                  timeout_q;
  logic                  idle_q;
  logic [15:0]           frame_count_q;
  logic [15:0]           frame_count_d;
  logic [WD_W-1:0]       wd_q;
  logic [WD_W-1:0]       wd_d;
  logic                  accepted;
`ifdef UART_TX_GAP_EN
  logic [GAP_W-1:0]      gap_q;
`endif

  assign frame_count_d = frame_count_q + 16'd1;
  assign wd_d          = wd_q + 1'b1;
  // Busy alone also counts as acceptance in case the started pulse is missed.
  assign accepted      = bus.tx_started | bus.tx_busy;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      data_q        <= '0;
      valid_q       <= 1'b0;
      rd_inc_q      <= 1'b0;
      timeout_q     <= 1'b0;
      idle_q        <= 1'b1;
      frame_count_q <= 16'd0;
      wd_q          <= '0;
`ifdef UART_TX_GAP_EN
      gap_q         <= '0;
`endif
    end else begin
      rd_inc_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Head is sampled here; a pop during LOAD cannot corrupt the held byte.
          if (!bus.fifo_empty && !bus.tx_busy) begin
            data_q   <= bus.fifo_rd_data;
            rd_inc_q <= 1'b1;
            idle_q   <= 1'b0;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          valid_q <= 1'b1;
          wd_q    <= '0;
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (accepted) begin
            valid_q <= 1'b0;
            wd_q    <= '0;
            state_q <= S_WAIT_DONE;
          end else if (wd_q == WD_LAST) begin
            timeout_q <= 1'b1;
            valid_q   <= 1'b0;
            wd_q      <= '0;
            state_q   <= S_RETRY;
          end else begin
            wd_q <= wd_d;
          end
        end
        S_RETRY: begin
          valid_q <= 1'b1;
          state_q <= S_REQ;
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            frame_count_q <= frame_count_d;
`ifdef UART_TX_GAP_EN
            if (gap_cycles_i != '0) begin
              gap_q   <= gap_cycles_i;
              state_q <= S_GAP;
            end else begin
              idle_q  <= 1'b1;
              state_q <= S_IDLE;
            end
`else
            idle_q  <= 1'b1;
            state_q <= S_IDLE;
`endif
          end
        end
`ifdef UART_TX_GAP_EN
        S_GAP: begin
          if (gap_q == GAP_W'(1)) begin
            idle_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
`endif
        default: begin
          valid_q <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_rd_inc   = rd_inc_q;
  assign bus.tx_p_data     = data_q;
  assign bus.tx_data_valid = valid_q;
  assign frame_count_o     = frame_count_q;
  assign timeout_err_o     = timeout_q;
  assign idle_o            = idle_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed scoreboard bench for uart_tx_feeder (optional UART_TX_GAP_EN part).
module tb_uart_tx_feeder;
  localparam int DW = 8;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.DATA_WIDTH(DW)) bus ();
  logic [15:0] frame_count;
  logic        timeout_err;
  logic        idle;
`ifdef UART_TX_GAP_EN
  logic [7:0]  gap_cycles = 8'd0;
`endif

  uart_tx_feeder #(
    .DATA_WIDTH(DW),
`ifdef UART_TX_GAP_EN
    .GAP_W(8),
`endif
    .START_TIMEOUT(ST)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .bus(bus),
`ifdef UART_TX_GAP_EN
    .gap_cycles_i(gap_cycles),
`endif
    .frame_count_o(frame_count),
    .timeout_err_o(timeout_err),
    .idle_o(idle)
  );

  logic [7:0] fifo_q[$];
  logic [7:0] sb_q[$];
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int rd_inc_cnt = 0;
  bit accept_en = 1'b1;
  int acc_delay = 3;
  int busy_len = 6;
  int vcnt = 0;
  int busy_left = 0;
  int last_fall = -100;
  int last_diff = -1;
  int last_to = -1;
  int to_cnt = 0;
  bit to_follow = 1'b0;
  logic [7:0] to_byte = 8'h00;
  logic prev_busy;
  logic [31:0] exp_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    sb_q.push_back(b);
  endtask

  task automatic wait_count(input logic [15:0] n, input int lim, input string tag);
    int i = 0;
    while (frame_count !== n && i < lim) begin
      step();
      i++;
    end
    chk(tag, {16'd0, frame_count}, {16'd0, n});
  endtask

  task automatic pulse_reset();
    step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // FIFO model, transmitter model and monitors share one process so their ordering is fixed.
  always @(negedge clk) begin
    cyc++;
    prev_busy = bus.tx_busy;
    if (!rst_n) begin
      bus.tx_started = 1'b0;
      bus.tx_busy    = 1'b0;
      busy_left      = 0;
      vcnt           = 0;
      rd_inc_cnt     = 0;
      to_cnt         = 0;
      last_to        = -1;
      to_follow      = 1'b0;
    end else begin
      if (bus.fifo_rd_inc) begin
        rd_inc_cnt++;
        last_diff = cyc - last_fall;
        chk("rd_inc_while_empty", {31'd0, bus.fifo_empty}, 32'd0);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      bus.tx_started = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.tx_busy = 1'b0;
      end else if (bus.tx_data_valid && accept_en) begin
        vcnt++;
        if (vcnt >= acc_delay) begin
          vcnt           = 0;
          bus.tx_started = 1'b1;
          bus.tx_busy    = 1'b1;
          busy_left      = busy_len;
          exp_byte       = (sb_q.size() > 0) ? {24'd0, sb_q.pop_front()} : 32'hDEAD;
          chk("tx_byte", {24'd0, bus.tx_p_data}, exp_byte);
        end
      end else begin
        vcnt = 0;
      end
      if (prev_busy === 1'b1 && bus.tx_busy === 1'b0) last_fall = cyc;
      if (to_follow) begin
        chk("valid_after_retry", {31'd0, bus.tx_data_valid}, 32'd1);
        to_follow = 1'b0;
      end
      if (timeout_err) begin
        to_cnt++;
        if (last_to >= 0) chk("timeout_period", cyc - last_to, 32'd5);
        last_to = cyc;
        chk("timeout_valid_low", {31'd0, bus.tx_data_valid}, 32'd0);
        chk("timeout_data_held", {24'd0, bus.tx_p_data}, {24'd0, to_byte});
        to_follow = 1'b1;
      end
    end
    bus.fifo_empty   = (fifo_q.size() == 0);
    bus.fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    repeat (3) step();
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_valid", {31'd0, bus.tx_data_valid}, 32'd0);
    chk("rst_rd_inc", {31'd0, bus.fifo_rd_inc}, 32'd0);
    chk("rst_data", {24'd0, bus.tx_p_data}, 32'd0);
    chk("rst_count", {16'd0, frame_count}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // single byte, accepted 3 cycles after valid
    push(8'hA5);
    step();
    step();
    chk("t1_rd_inc", {31'd0, bus.fifo_rd_inc}, 32'd1);
    chk("t1_valid_in_load", {31'd0, bus.tx_data_valid}, 32'd0);
    chk("t1_idle_low", {31'd0, idle}, 32'd0);
    chk("t1_data", {24'd0, bus.tx_p_data}, 32'hA5);
    step();
    chk("t1_valid", {31'd0, bus.tx_data_valid}, 32'd1);
    chk("t1_rd_inc_once", {31'd0, bus.fifo_rd_inc}, 32'd0);
    wait_count(16'd1, 60, "t1_count");
    chk("t1_rd_inc_cnt", rd_inc_cnt, 32'd1);
    chk("t1_valid_after", {31'd0, bus.tx_data_valid}, 32'd0);

    // four bytes in order
    pulse_reset();
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_count(16'd4, 300, "t2_count");
    chk("t2_rd_inc_cnt", rd_inc_cnt, 32'd4);
    chk("t2_busy_to_load", last_diff, 32'd2);
    chk("t2_sb_empty", sb_q.size(), 32'd0);

    // watchdog retries, then late accept
    pulse_reset();
    accept_en = 1'b0;
    to_byte = 8'h5A;
    push(8'h5A);
    i = 0;
    while (to_cnt < 4 && i < 100) begin
      step();
      i++;
    end
    chk("t3_timeouts_seen", {31'd0, (to_cnt >= 4)}, 32'd1);
    chk("t3_single_pop", rd_inc_cnt, 32'd1);
    chk("t3_data_held", {24'd0, bus.tx_p_data}, 32'h5A);
    accept_en = 1'b1;
    wait_count(16'd1, 60, "t3_count");

    // reset while waiting for frame end
    pulse_reset();
    busy_len = 20;
    push(8'hC3);
    i = 0;
    while (bus.tx_busy !== 1'b1 && i < 30) begin
      step();
      i++;
    end
    step();
    chk("t4_in_wait_done", {30'd0, bus.tx_busy, bus.tx_data_valid}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t4_valid", {31'd0, bus.tx_data_valid}, 32'd0);
    chk("t4_data", {24'd0, bus.tx_p_data}, 32'd0);
    chk("t4_idle", {31'd0, idle}, 32'd1);
    chk("t4_count", {16'd0, frame_count}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    busy_len = 6;
    repeat (10) step();
    chk("t4_no_rd_inc", rd_inc_cnt, 32'd0);
    chk("t4_idle_after", {31'd0, idle}, 32'd1);

    // frame counter wrap
    force dut.frame_count_q = 16'hFFFF;
    step();
    release dut.frame_count_q;
    step();
    chk("t5_preload", {16'd0, frame_count}, 32'hFFFF);
    push(8'h7E);
    wait_count(16'd0, 60, "t5_wrap");

`ifdef UART_TX_GAP_EN
    // inter-frame gap
    pulse_reset();
    gap_cycles = 8'd10;
    push(8'h11); push(8'h22);
    wait_count(16'd2, 200, "t6_count_gap");
    chk("t6_gap_spacing", last_diff, 32'd12);
    gap_cycles = 8'd0;
    push(8'h33); push(8'h44);
    wait_count(16'd4, 200, "t6_count_nogap");
    chk("t6_nogap_spacing", last_diff, 32'd2);
`endif

    chk("end_sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
